// File: rtl/clkgen_seg7_mux.sv
`default_nettype none
// clkgen_seg7_mux: 500 Hz / 5 Hz / 1 Hz dividers plus a 4-digit multiplexed seven-segment scanner.
// Optional macro HEX_DIGITS_EN: show A-F glyphs for digit values 10-15 (otherwise blank). Rev 1.0
module clkgen_seg7_mux #(
  parameter int HALF_M    = 100000,
  parameter int HALF_FIVE = 10000000,
  parameter int HALF_ONE  = 50000000
) (
  input  logic       clk_i,
  input  logic       rst,
  input  logic [3:0] min_tens,
  input  logic [3:0] min_ones,
  input  logic [3:0] sec_tens,
  input  logic [3:0] sec_ones,
  output logic       clk_m,
  output logic       clk_five,
  output logic       clk_one,
  output logic [3:0] an,
  output logic [7:0] seg
);

  localparam int W_M    = (HALF_M    > 1) ? $clog2(HALF_M)    : 1;
  localparam int W_FIVE = (HALF_FIVE > 1) ? $clog2(HALF_FIVE) : 1;
  localparam int W_ONE  = (HALF_ONE  > 1) ? $clog2(HALF_ONE)  : 1;

  localparam logic [W_M-1:0]    LAST_M    = W_M'(HALF_M - 1);
  localparam logic [W_FIVE-1:0] LAST_FIVE = W_FIVE'(HALF_FIVE - 1);
  localparam logic [W_ONE-1:0]  LAST_ONE  = W_ONE'(HALF_ONE - 1);

  logic [W_M-1:0]    cnt_m;
  logic [W_FIVE-1:0] cnt_five;
  logic [W_ONE-1:0]  cnt_one;
  logic              wrap_m;
  logic              wrap_five;
  logic              wrap_one;
  logic              tick;

  assign wrap_m    = (cnt_m == LAST_M);
  assign wrap_five = (cnt_five == LAST_FIVE);
  assign wrap_one  = (cnt_one == LAST_ONE);

  // Each output toggles in the same cycle its counter wraps, giving period 2*HALF_x.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      cnt_m <= '0;
      clk_m <= 1'b0;
    end else if (wrap_m) begin
      cnt_m <= '0;
      clk_m <= ~clk_m;
    end else begin
      cnt_m <= cnt_m + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      cnt_five <= '0;
      clk_five <= 1'b0;
    end else if (wrap_five) begin
      cnt_five <= '0;
      clk_five <= ~clk_five;
    end else begin
      cnt_five <= cnt_five + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      cnt_one <= '0;
      clk_one <= 1'b0;
    end else if (wrap_one) begin
      cnt_one <= '0;
      clk_one <= ~clk_one;
    end else begin
      cnt_one <= cnt_one + 1'b1;
    end
  end

  // Refresh tick marks the cycle in which clk_m goes 0->1.
  assign tick = wrap_m & ~clk_m;

  function automatic logic [7:0] seg_of(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
`ifdef HEX_DIGITS_EN
      4'hA:    s = 8'h88;
      4'hB:    s = 8'h83;
      4'hC:    s = 8'hC6;
      4'hD:    s = 8'hA1;
      4'hE:    s = 8'h86;
      4'hF:    s = 8'h8E;
`endif
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  logic [1:0] idx;
  logic [3:0] cur_val;
  logic [3:0] cur_an;

  always_comb begin
    cur_val = sec_ones;
    cur_an  = 4'b1110;
    case (idx)
      2'd0: begin cur_val = sec_ones; cur_an = 4'b1110; end
      2'd1: begin cur_val = sec_tens; cur_an = 4'b1101; end
      2'd2: begin cur_val = min_ones; cur_an = 4'b1011; end
      default: begin cur_val = min_tens; cur_an = 4'b0111; end
    endcase
  end

  // Digit inputs are only looked at on the tick; an/seg hold in between.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      idx <= 2'd0;
      an  <= 4'b1111;
      seg <= 8'hFF;
    end else if (tick) begin
      an  <= cur_an;
      seg <= seg_of(cur_val);
      idx <= idx + 2'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clkgen_seg7_mux.sv
`default_nettype none
// Self-checking bench for clkgen_seg7_mux with small divider values.
module tb_clkgen_seg7_mux;

  localparam int HM = 2;
  localparam int HF = 10;
  localparam int HO = 50;

  logic       clk_i = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] min_tens = 4'd0;
  logic [3:0] min_ones = 4'd0;
  logic [3:0] sec_tens = 4'd0;
  logic [3:0] sec_ones = 4'd0;
  logic       clk_m;
  logic       clk_five;
  logic       clk_one;
  logic [3:0] an;
  logic [7:0] seg;

  always #5 clk_i = ~clk_i;

  clkgen_seg7_mux #(.HALF_M(HM), .HALF_FIVE(HF), .HALF_ONE(HO)) dut (
    .clk_i(clk_i), .rst(rst),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .clk_m(clk_m), .clk_five(clk_five), .clk_one(clk_one), .an(an), .seg(seg)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] mt, mo, st, so;
    logic [7:0] e0, e1, e2, e3;
  } vec_t;

  vec_t       tbl[6];
  logic [7:0] glyph[10];
  logic [3:0] an_pat[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wait_tick(input string name);
    logic prev;
    bit   ok;
    prev = clk_m;
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge clk_i);
      if (!prev && clk_m) ok = 1'b1;
      prev = clk_m;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s tick_timeout actual=none expected=clk_m_rise", name);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    rst = 1'b0;
  endtask

  task automatic set_digits(input logic [3:0] mt, input logic [3:0] mo,
                            input logic [3:0] st, input logic [3:0] so);
    min_tens = mt; min_ones = mo; sec_tens = st; sec_ones = so;
  endtask

  initial begin
    logic [7:0] ev;
    glyph = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    an_pat = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    // Expected seg per scan index 0..3 (sec_ones, sec_tens, min_ones, min_tens).
    tbl[0] = '{mt:4'd1, mo:4'd2, st:4'd3, so:4'd4, e0:8'h99, e1:8'hB0, e2:8'hA4, e3:8'hF9};
    tbl[1] = '{mt:4'd0, mo:4'd9, st:4'd5, so:4'd0, e0:8'hC0, e1:8'h92, e2:8'h90, e3:8'hC0};
    tbl[2] = '{mt:4'd6, mo:4'd7, st:4'd8, so:4'd1, e0:8'hF9, e1:8'h80, e2:8'hF8, e3:8'h82};
    tbl[3] = '{mt:4'd3, mo:4'd2, st:4'd9, so:4'd5, e0:8'h92, e1:8'h90, e2:8'hA4, e3:8'hB0};
`ifdef HEX_DIGITS_EN
    tbl[4] = '{mt:4'hE, mo:4'hB, st:4'hF, so:4'hA, e0:8'h88, e1:8'h8E, e2:8'h83, e3:8'h86};
    tbl[5] = '{mt:4'd0, mo:4'd0, st:4'hD, so:4'hC, e0:8'hC6, e1:8'hA1, e2:8'hC0, e3:8'hC0};
`else
    tbl[4] = '{mt:4'hE, mo:4'hB, st:4'hF, so:4'hA, e0:8'hFF, e1:8'hFF, e2:8'hFF, e3:8'hFF};
    tbl[5] = '{mt:4'd0, mo:4'd0, st:4'hD, so:4'hC, e0:8'hFF, e1:8'hFF, e2:8'hC0, e3:8'hC0};
`endif

    // Reset state
    @(negedge clk_i);
    @(negedge clk_i);
    check("rst_an", 32'(an), 32'h0000000F);
    check("rst_seg", 32'(seg), 32'h000000FF);
    check("rst_clk_m", 32'(clk_m), 0);
    check("rst_clk_five", 32'(clk_five), 0);
    check("rst_clk_one", 32'(clk_one), 0);
    rst = 1'b0;

    // Divider waveforms: after edge k each output has toggled floor(k/HALF) times.
    for (int k = 1; k <= 220; k++) begin
      @(negedge clk_i);
      check($sformatf("clk_m_e%0d", k), 32'(clk_m), 32'((k / HM) % 2));
      check($sformatf("clk_five_e%0d", k), 32'(clk_five), 32'((k / HF) % 2));
      check($sformatf("clk_one_e%0d", k), 32'(clk_one), 32'((k / HO) % 2));
    end

    // Table vectors: full scan from reset.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      set_digits(tbl[v].mt, tbl[v].mo, tbl[v].st, tbl[v].so);
      for (int i = 0; i < 4; i++) begin
        case (i)
          0: ev = tbl[v].e0;
          1: ev = tbl[v].e1;
          2: ev = tbl[v].e2;
          default: ev = tbl[v].e3;
        endcase
        wait_tick($sformatf("vec%0d_idx%0d", v, i));
        check($sformatf("vec%0d_an%0d", v, i), 32'(an), 32'(an_pat[i]));
        check($sformatf("vec%0d_seg%0d", v, i), 32'(seg), 32'(ev));
      end
    end

    // All ten glyphs on successive index-0 slots, also exercising wrap.
    do_reset();
    set_digits(4'd1, 4'd2, 4'd3, 4'd0);
    for (int g = 0; g < 10; g++) begin
      sec_ones = 4'(g);
      wait_tick($sformatf("glyph%0d", g));
      check($sformatf("glyph%0d_an", g), 32'(an), 32'h0000000E);
      check($sformatf("glyph%0d_seg", g), 32'(seg), 32'(glyph[g]));
      for (int j = 0; j < 3; j++) wait_tick($sformatf("glyph%0d_skip%0d", g, j));
    end

    // Async reset mid-scan at index 2 with clk_m high.
    do_reset();
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    for (int i = 0; i < 3; i++) wait_tick($sformatf("ar_pre%0d", i));
    check("ar_pre_seg", 32'(seg), 32'h000000A4);
    check("ar_pre_clk_m", 32'(clk_m), 1);
    check("ar_pre_clk_five", 32'(clk_five), 1);
    #1 rst = 1'b1;
    #1;
    check("ar_an", 32'(an), 32'h0000000F);
    check("ar_seg", 32'(seg), 32'h000000FF);
    check("ar_clk_m", 32'(clk_m), 0);
    check("ar_clk_five", 32'(clk_five), 0);
    check("ar_clk_one", 32'(clk_one), 0);
    @(negedge clk_i);
    rst = 1'b0;
    wait_tick("ar_post");
    check("ar_post_an", 32'(an), 32'h0000000E);
    check("ar_post_seg", 32'(seg), 32'h00000099);

    // Inputs changed between ticks are not visible until their own slot.
    do_reset();
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    wait_tick("hold_t0");
    wait_tick("hold_t1");
    sec_tens = 4'd9;
    sec_ones = 4'd7;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("hold_an_c%0d", c), 32'(an), 32'h0000000D);
      check($sformatf("hold_seg_c%0d", c), 32'(seg), 32'h000000B0);
      @(negedge clk_i);
    end
    wait_tick("hold_t2");
    wait_tick("hold_t3");
    wait_tick("hold_t4");
    check("hold_new0_an", 32'(an), 32'h0000000E);
    check("hold_new0_seg", 32'(seg), 32'h000000F8);
    wait_tick("hold_t5");
    check("hold_new1_an", 32'(an), 32'h0000000D);
    check("hold_new1_seg", 32'(seg), 32'h00000090);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
